// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU widths and opcode encoding
package ppu_pkg;

    localparam int OP_SIZE   = 3;
    localparam int PPU_WORD  = 32;
    localparam int PPU_DEPTH = 8;

    typedef enum logic [OP_SIZE-1:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_MAC   = 3'd3,
        OP_MIN   = 3'd4,
        OP_MAX   = 3'd5,
        OP_RELU  = 3'd6,
        OP_SHIFT = 3'd7
    } ppu_op_e;

endpackage

// File: rtl/ppu_sync_fifo.sv
// rtl/ppu_sync_fifo.sv - synchronous FIFO, head read from storage registers
module ppu_sync_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;

    // Head is masked so an empty FIFO never shows stale storage.
    assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ppu_result_collector.sv
// rtl/ppu_result_collector.sv - pairs PPU results with issue-order opcodes, issues credits
module ppu_result_collector #(
    parameter int  WORD    = ppu_pkg::PPU_WORD,
    parameter int  OP_SIZE = ppu_pkg::OP_SIZE,
    parameter int  DEPTH   = ppu_pkg::PPU_DEPTH,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_i,
    input  logic [OP_SIZE-1:0] issue_op_i,
    output logic               can_issue_o,
    input  logic               ppu_valid_i,
    input  logic [WORD-1:0]    ppu_result_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WORD-1:0]    out_data_o,
    output logic [OP_SIZE-1:0] out_op_o,
    output logic [CW-1:0]      count_o,
    output logic [CW-1:0]      inflight_o,
    output logic               err_o
);

    localparam int RW = OP_SIZE + WORD;

    logic [CW-1:0]      inflight_q;
    logic [CW-1:0]      res_count;
    logic [CW-1:0]      tag_count;
    logic [CW:0]        used;
    logic [OP_SIZE-1:0] tag_head;
    logic [RW-1:0]      res_head;
    logic               tag_full;
    logic               tag_empty;
    logic               res_full;
    logic               res_empty;
    logic               issue_ok;
    logic               issue_drop;
    logic               result_ok;
    logic               result_spurious;
    logic               out_pop;
    logic               unused_status;

    // Credits count both buffered results and ops still inside the PPU,
    // because the PPU cannot be stalled once an op is issued.
    assign used        = {1'b0, res_count} + {1'b0, inflight_q};
    assign can_issue_o = (used < (CW + 1)'(DEPTH));

    assign issue_ok        = issue_i && can_issue_o;
    assign issue_drop      = issue_i && !can_issue_o;
    assign result_ok       = ppu_valid_i && (inflight_q != '0);
    assign result_spurious = ppu_valid_i && (inflight_q == '0);
    assign out_pop         = out_valid_o && out_ready_i;

    ppu_sync_fifo #(
        .W     (OP_SIZE),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (issue_ok),
        .push_data_i (issue_op_i),
        .pop_i       (result_ok),
        .pop_data_o  (tag_head),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    ppu_sync_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (result_ok),
        .push_data_i ({tag_head, ppu_result_i}),
        .pop_i       (out_pop),
        .pop_data_o  (res_head),
        .count_o     (res_count),
        .full_o      (res_full),
        .empty_o     (res_empty)
    );

    assign unused_status = ^{tag_count, tag_full, tag_empty, res_full};

    assign out_valid_o = !res_empty;
    assign out_data_o  = res_head[WORD-1:0];
    assign out_op_o    = res_head[WORD +: OP_SIZE];
    assign count_o     = res_count;
    assign inflight_o  = inflight_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            err_o      <= 1'b0;
        end else begin
            case ({issue_ok, result_ok})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (issue_drop || result_spurious) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_result_collector.sv
// tb/tb_ppu_result_collector.sv - scoreboard bench for ppu_result_collector
module tb_ppu_result_collector;

    logic        clk_i;
    logic        rst_ni;
    logic        issue_i;
    logic [2:0]  issue_op_i;
    logic        can_issue_o;
    logic        ppu_valid_i;
    logic [31:0] ppu_result_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [2:0]  out_op_o;
    logic [3:0]  count_o;
    logic [3:0]  inflight_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [34:0] sb_q[$];

    ppu_result_collector dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_i      (issue_i),
        .issue_op_i   (issue_op_i),
        .can_issue_o  (can_issue_o),
        .ppu_valid_i  (ppu_valid_i),
        .ppu_result_i (ppu_result_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_op_o     (out_op_o),
        .count_o      (count_o),
        .inflight_o   (inflight_o),
        .err_o        (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [2:0] op, input logic [31:0] data);
        sb_q.push_back({op, data});
    endtask

    // Called at posedge+1; applies inputs for exactly one rising edge.
    task automatic drive(input logic iss, input logic [2:0] op, input logic pv, input logic [31:0] res);
        issue_i      = iss;
        issue_op_i   = op;
        ppu_valid_i  = pv;
        ppu_result_i = res;
        @(posedge clk_i);
        #1;
        issue_i      = 1'b0;
        issue_op_i   = '0;
        ppu_valid_i  = 1'b0;
        ppu_result_i = '0;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks head stability under stall.
    initial begin
        logic        hold;
        logic [34:0] held;
        logic [34:0] exp;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || !out_valid_o) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("head_stable", {29'd0, out_op_o}, {29'd0, held[34:32]});
                    chk("head_stable_data", out_data_o, held[31:0]);
                end
                if (out_ready_i) begin
                    hold = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("out_op", {29'd0, out_op_o}, {29'd0, exp[34:32]});
                        chk("out_data", out_data_o, exp[31:0]);
                    end
                end else begin
                    hold = 1'b1;
                    held = {out_op_o, out_data_o};
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni       = 1'b0;
        issue_i      = 1'b0;
        issue_op_i   = '0;
        ppu_valid_i  = 1'b0;
        ppu_result_i = '0;
        out_ready_i  = 1'b0;

        // 1. reset values
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_can_issue", {31'd0, can_issue_o}, 32'd1);
        chk("rst_count", {28'd0, count_o}, 32'd0);
        chk("rst_inflight", {28'd0, inflight_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_out_data", out_data_o, 32'd0);
        @(posedge clk_i);
        #1;

        // 2. single op, result three cycles later
        out_ready_i = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 32'd0);
        chk("t2_inflight", {28'd0, inflight_o}, 32'd1);
        drive(1'b0, 3'd0, 1'b0, 32'd0);
        drive(1'b0, 3'd0, 1'b0, 32'd0);
        expect_out(3'd1, 32'h4000_0000);
        drive(1'b0, 3'd0, 1'b1, 32'h4000_0000);
        chk("t2_out_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t2_out_data", out_data_o, 32'h4000_0000);
        chk("t2_out_op", {29'd0, out_op_o}, 32'd1);
        drive(1'b0, 3'd0, 1'b0, 32'd0);
        chk("t2_count", {28'd0, count_o}, 32'd0);
        chk("t2_inflight_end", {28'd0, inflight_o}, 32'd0);

        // 3. fill all credits, overflow issue, then drain in order
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t3_can_before_8th", {31'd0, can_issue_o}, 32'd1);
            drive(1'b1, 3'(i), 1'b0, 32'd0);
        end
        chk("t3_can_after_8th", {31'd0, can_issue_o}, 32'd0);
        chk("t3_inflight8", {28'd0, inflight_o}, 32'd8);
        chk("t3_err_pre", {31'd0, err_o}, 32'd0);
        drive(1'b1, 3'd5, 1'b0, 32'd0);
        chk("t3_err_overflow", {31'd0, err_o}, 32'd1);
        chk("t3_inflight_still8", {28'd0, inflight_o}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            expect_out(3'(i), 32'h100 + 32'(i));
            drive(1'b0, 3'd0, 1'b1, 32'h100 + 32'(i));
        end
        chk("t3_count8", {28'd0, count_o}, 32'd8);
        chk("t3_inflight0", {28'd0, inflight_o}, 32'd0);
        chk("t3_can_full", {31'd0, can_issue_o}, 32'd0);
        drive(1'b0, 3'd0, 1'b0, 32'd0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && count_o != 0; k++) begin
            @(posedge clk_i);
            #1;
        end
        out_ready_i = 1'b0;
        chk("t3_drained", {28'd0, count_o}, 32'd0);
        chk("t3_sb_empty", sb_q.size(), 32'd0);

        // 4. same-cycle issue and result
        drive(1'b1, 3'd5, 1'b0, 32'd0);
        expect_out(3'd5, 32'h3C00);
        drive(1'b1, 3'd2, 1'b1, 32'h3C00);
        chk("t4_inflight", {28'd0, inflight_o}, 32'd1);
        chk("t4_count", {28'd0, count_o}, 32'd1);
        chk("t4_op_old_tag", {29'd0, out_op_o}, 32'd5);
        chk("t4_data", out_data_o, 32'h3C00);
        expect_out(3'd2, 32'h77);
        drive(1'b0, 3'd0, 1'b1, 32'h77);

        // 5. push and pop together at count=3
        expect_out(3'd3, 32'h88);
        drive(1'b1, 3'd3, 1'b0, 32'd0);
        drive(1'b0, 3'd0, 1'b1, 32'h88);
        chk("t5_count3", {28'd0, count_o}, 32'd3);
        drive(1'b1, 3'd4, 1'b0, 32'd0);
        out_ready_i = 1'b1;
        expect_out(3'd4, 32'h99);
        drive(1'b0, 3'd0, 1'b1, 32'h99);
        out_ready_i = 1'b0;
        chk("t5_count_same", {28'd0, count_o}, 32'd3);
        chk("t5_head_op", {29'd0, out_op_o}, 32'd2);
        chk("t5_head_data", out_data_o, 32'h77);

        // clean slate before the spurious-result case
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sb_q.delete();
        chk("t6_err_cleared", {31'd0, err_o}, 32'd0);

        // 6. spurious result, then async reset mid-drain
        drive(1'b1, 3'd6, 1'b0, 32'd0);
        drive(1'b1, 3'd7, 1'b0, 32'd0);
        expect_out(3'd6, 32'h11);
        drive(1'b0, 3'd0, 1'b1, 32'h11);
        expect_out(3'd7, 32'h22);
        drive(1'b0, 3'd0, 1'b1, 32'h22);
        drive(1'b0, 3'd0, 1'b1, 32'hDEAD);
        chk("t6_err_spurious", {31'd0, err_o}, 32'd1);
        chk("t6_count_unchanged", {28'd0, count_o}, 32'd2);
        chk("t6_inflight0", {28'd0, inflight_o}, 32'd0);
        out_ready_i = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'd0);
        chk("t6_mid_drain_count", {28'd0, count_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t6_rst_count", {28'd0, count_o}, 32'd0);
        chk("t6_rst_err", {31'd0, err_o}, 32'd0);
        chk("t6_rst_can", {31'd0, can_issue_o}, 32'd1);
        chk("t6_rst_data", out_data_o, 32'd0);
        chk("t6_rst_op", {29'd0, out_op_o}, 32'd0);
        sb_q.delete();
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
